fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/chip8_pkg.sv | 16 +
 rtl/fb_byte_serializer.sv | 36 +++
 rtl/fb_scanout.sv | 132 +++++++++++++
 tb/tb_fb_scanout.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants and the scan-out state encoding.
// Framebuffer geometry is fixed at 64x32 monochrome, packed 8 pixels per byte.
package chip8_pkg;
    localparam int FB_ADDR_W = 12;
    localparam logic [FB_ADDR_W-1:0] FB_BASE = 12'h100;
    localparam int FB_WIDTH  = 64;
    localparam int FB_HEIGHT = 32;
    localparam int FB_BYTES  = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHIFT = 2'd3
    } scan_state_t;
endpackage

// File: rtl/fb_byte_serializer.sv
// 8-bit load/shift register that hands out one framebuffer byte MSB first,
// with a bit counter and a flag marking the eighth bit.
module fb_byte_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    output logic       msb,
    output logic [2:0] bit_cnt,
    output logic       last_bit
);
    logic [7:0] shreg_r;
    logic [2:0] cnt_r;

    // Shift register and bit counter; a load restarts the count at bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r <= 8'h00;
            cnt_r   <= 3'd0;
        end else if (load) begin
            shreg_r <= load_data;
            cnt_r   <= 3'd0;
        end else if (shift) begin
            shreg_r <= {shreg_r[6:0], 1'b0};
            cnt_r   <= cnt_r + 3'd1;
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
        end
    end

    assign msb      = shreg_r[7];
    assign bit_cnt  = cnt_r;
    assign last_bit = (cnt_r == 3'd7);
endmodule

// File: rtl/fb_scanout.sv
// Reads the CHIP-8 framebuffer one byte at a time from shared RAM and streams
// it out as 2048 pixels with x/y coordinates over a valid/ready handshake.
module fb_scanout #(
    parameter logic [chip8_pkg::FB_ADDR_W-1:0] FB_BASE = chip8_pkg::FB_BASE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             mem_read_enable,
    input  logic                             mem_grant,
    output logic [chip8_pkg::FB_ADDR_W-1:0]  mem_read_address,
    input  logic [7:0]                       mem_read_data,
    output logic                             pixel_valid,
    input  logic                             pixel_ready,
    output logic                             pixel,
    output logic [5:0]                       pixel_x,
    output logic [4:0]                       pixel_y
);
    import chip8_pkg::*;

    scan_state_t state_r;
    scan_state_t state_nxt_s;
    logic [7:0]  byte_idx_r;
    logic        load_s;
    logic        shift_s;
    logic        byte_clr_s;
    logic        byte_inc_s;
    logic        frame_done_s;
    logic        ser_msb_s;
    logic [2:0]  bit_cnt_s;
    logic        last_bit_s;
    logic        last_byte_s;

    assign last_byte_s = (byte_idx_r == 8'(FB_BYTES - 1));

    fb_byte_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .load_data (mem_read_data),
        .shift     (shift_s),
        .msb       (ser_msb_s),
        .bit_cnt   (bit_cnt_s),
        .last_bit  (last_bit_s)
    );

    // Scan state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Byte index; the last byte's increment wraps it back to 0 for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx_r <= 8'd0;
        end else if (byte_clr_s) begin
            byte_idx_r <= 8'd0;
        end else if (byte_inc_s) begin
            byte_idx_r <= byte_idx_r + 8'd1;
        end else begin
            byte_idx_r <= byte_idx_r;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt_s  = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        byte_clr_s   = 1'b0;
        byte_inc_s   = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    byte_clr_s  = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_grant) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                load_s      = 1'b1;
                state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (pixel_ready) begin
                    shift_s = 1'b1;
                    if (last_bit_s) begin
                        byte_inc_s = 1'b1;
                        if (last_byte_s) begin
                            frame_done_s = 1'b1;
                            state_nxt_s  = ST_IDLE;
                        end else begin
                            state_nxt_s  = ST_REQ;
                        end
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Coordinates follow directly from byte index and bit position.
    assign busy             = (state_r != ST_IDLE);
    assign frame_done       = frame_done_s;
    assign mem_read_enable  = (state_r == ST_REQ);
    assign mem_read_address = FB_BASE + {4'h0, byte_idx_r};
    assign pixel_valid      = (state_r == ST_SHIFT);
    assign pixel            = pixel_valid & ser_msb_s;
    assign pixel_x          = {byte_idx_r[2:0], bit_cnt_s};
    assign pixel_y          = byte_idx_r[7:3];
endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: RAM model, pixel scoreboard computed from
// the framebuffer layout, directed stall/reset scenarios and randomized handshakes.
module tb_fb_scanout;
    localparam logic [11:0] BASE = 12'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        mem_read_enable;
    logic        mem_grant;
    logic [11:0] mem_read_address;
    logic [7:0]  mem_read_data = 8'h00;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel;
    logic [5:0]  pixel_x;
    logic [4:0]  pixel_y;

    always #5 clk = ~clk;

    fb_scanout #(.FB_BASE(BASE)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .frame_done       (frame_done),
        .mem_read_enable  (mem_read_enable),
        .mem_grant        (mem_grant),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .pixel_valid      (pixel_valid),
        .pixel_ready      (pixel_ready),
        .pixel            (pixel),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y)
    );

    logic [7:0] mem [0:4095];
    int total = 0;
    int bad   = 0;

    logic        mon_clr   = 1'b1;
    int          rd_cnt    = 0;
    int          pix_cnt   = 0;
    int          pix_err   = 0;
    int          fd_cnt    = 0;
    int          fd_err    = 0;
    int          stall_err = 0;
    int          gnt_err   = 0;
    int          lit_cnt   = 0;
    logic        last_pix  = 1'b0;
    logic        pstall    = 1'b0;
    logic [5:0]  px        = 6'd0;
    logic [4:0]  py        = 5'd0;
    logic        pp        = 1'b0;
    logic        gprev     = 1'b0;
    logic [11:0] paddr     = 12'd0;
    int          rstall    = 0;
    int          gstall    = 0;

    // Expected pixel straight from the framebuffer layout.
    function automatic logic ref_pixel(input int x, input int y);
        logic [7:0] b;
        b = mem[BASE + 12'(y * 8 + x / 8)];
        return b[7 - (x % 8)];
    endfunction

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mon_clr) begin
            rd_cnt <= 0;
        end else if (mem_read_enable && mem_grant) begin
            mem_read_data <= mem[mem_read_address];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    // Scoreboard: samples the handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (mon_clr) begin
            pix_cnt <= 0; pix_err <= 0; fd_cnt <= 0; fd_err <= 0;
            stall_err <= 0; gnt_err <= 0; lit_cnt <= 0; last_pix <= 1'b0;
            pstall <= 1'b0; gprev <= 1'b0;
        end else begin
            if (pstall && !(pixel_valid === 1'b1 && pixel_x === px && pixel_y === py && pixel === pp))
                stall_err <= stall_err + 1;
            if (gprev && !(mem_read_enable === 1'b1 && mem_read_address === paddr))
                gnt_err <= gnt_err + 1;
            if (pixel_valid && pixel_ready) begin
                if (pixel_x !== 6'(pix_cnt % 64) || pixel_y !== 5'(pix_cnt / 64) ||
                    pixel !== ref_pixel(pix_cnt % 64, pix_cnt / 64))
                    pix_err <= pix_err + 1;
                if (frame_done !== (pix_cnt == 2047))
                    fd_err <= fd_err + 1;
                if (frame_done)
                    fd_cnt <= fd_cnt + 1;
                pix_cnt  <= pix_cnt + 1;
                lit_cnt  <= lit_cnt + int'(pixel);
                last_pix <= pixel;
            end else if (frame_done !== 1'b0) begin
                fd_err <= fd_err + 1;
            end
            pstall <= pixel_valid && !pixel_ready;
            px     <= pixel_x;
            py     <= pixel_y;
            pp     <= pixel;
            gprev  <= mem_read_enable && !mem_grant;
            paddr  <= mem_read_address;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
        chk({tag, "_ren"}, 32'(mem_read_enable), 32'd0);
        chk({tag, "_addr"}, 32'(mem_read_address), 32'(BASE));
        chk({tag, "_pvalid"}, 32'(pixel_valid), 32'd0);
        chk({tag, "_pixel"}, 32'(pixel), 32'd0);
        chk({tag, "_x"}, 32'(pixel_x), 32'd0);
        chk({tag, "_y"}, 32'(pixel_y), 32'd0);
    endtask

    // mode 0: ready/grant high; 1: random; 2: directed stalls at (3,0) and byte 0x10.
    task automatic run_frame(input int mode, output int lat, output bit done);
        int n;
        n = 0; done = 1'b0; rstall = 0; gstall = 0;
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        while (!done && n < 12000) begin
            @(posedge clk);
            #1;
            start = (n == 100);
            if (mode == 1) begin
                pixel_ready = ($urandom_range(0, 3) != 0);
                mem_grant   = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                pixel_ready = 1'b1;
                mem_grant   = 1'b1;
                if (pixel_valid && pixel_x == 6'd3 && pixel_y == 5'd0 && rstall < 5) begin
                    pixel_ready = 1'b0;
                    rstall++;
                end
                if (mem_read_enable && mem_read_address == 12'h110 && gstall < 7) begin
                    mem_grant = 1'b0;
                    gstall++;
                end
            end else begin
                pixel_ready = 1'b1;
                mem_grant   = 1'b1;
            end
            @(negedge clk);
            n++;
            if (frame_done) done = 1'b1;
        end
        lat = n;
        @(posedge clk);
        #1 pixel_ready = 1'b1; mem_grant = 1'b1; start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  lat;
        bit  done;
        int  n;
        bit  hit;
        int  fd_before;

        reset = 1'b1; start = 1'b0; mem_grant = 1'b1; pixel_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Two lit bytes on row 8, all high handshakes, mid-frame start ignored.
        mem[12'h141] = 8'h0F;
        mem[12'h142] = 8'hF0;
        run_frame(0, lat, done);
        chk("f1_done", 32'(done), 32'd1);
        chk("f1_latency", 32'(lat >= 2558 && lat <= 2562), 32'd1);
        chk("f1_pix_cnt", 32'(pix_cnt), 32'd2048);
        chk("f1_pix_err", 32'(pix_err), 32'd0);
        chk("f1_lit", 32'(lit_cnt), 32'd8);
        chk("f1_reads", 32'(rd_cnt), 32'd256);
        chk("f1_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("f1_fd_err", 32'(fd_err), 32'd0);
        chk("f1_busy_after", 32'(busy), 32'd0);
        chk("f1_ren_after", 32'(mem_read_enable), 32'd0);

        // Directed stalls on random contents.
        for (int i = 0; i < 256; i++) mem[BASE + 12'(i)] = 8'($urandom);
        run_frame(2, lat, done);
        chk("f2_done", 32'(done), 32'd1);
        chk("f2_ready_stalls", 32'(rstall), 32'd5);
        chk("f2_grant_stalls", 32'(gstall), 32'd7);
        chk("f2_stall_stable", 32'(stall_err), 32'd0);
        chk("f2_grant_stable", 32'(gnt_err), 32'd0);
        chk("f2_pix_cnt", 32'(pix_cnt), 32'd2048);
        chk("f2_pix_err", 32'(pix_err), 32'd0);
        chk("f2_reads", 32'(rd_cnt), 32'd256);
        chk("f2_fd_cnt", 32'(fd_cnt), 32'd1);

        // Random handshakes, last pixel lit.
        for (int i = 0; i < 256; i++) mem[BASE + 12'(i)] = 8'($urandom);
        mem[12'h1FF] = 8'h01;
        run_frame(1, lat, done);
        chk("f3_done", 32'(done), 32'd1);
        chk("f3_pix_cnt", 32'(pix_cnt), 32'd2048);
        chk("f3_pix_err", 32'(pix_err), 32'd0);
        chk("f3_last_pixel", 32'(last_pix), 32'd1);
        chk("f3_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("f3_fd_err", 32'(fd_err), 32'd0);
        chk("f3_stall_stable", 32'(stall_err), 32'd0);
        chk("f3_grant_stable", 32'(gnt_err), 32'd0);
        chk("f3_reads", 32'(rd_cnt), 32'd256);
        chk("f3_busy_after", 32'(busy), 32'd0);

        // Reset mid-frame at pixel (20,10), then a clean frame.
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; hit = 1'b0;
        while (!hit && n < 4000) begin
            @(negedge clk);
            n++;
            if (pixel_valid && pixel_x == 6'd20 && pixel_y == 5'd10) hit = 1'b1;
        end
        chk("rst_reached", 32'(hit), 32'd1);
        fd_before = fd_cnt;
        mon_clr = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        chk("mid_rst_no_fd", 32'(fd_before), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(0, lat, done);
        chk("f4_done", 32'(done), 32'd1);
        chk("f4_pix_cnt", 32'(pix_cnt), 32'd2048);
        chk("f4_pix_err", 32'(pix_err), 32'd0);
        chk("f4_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("f4_reads", 32'(rd_cnt), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
